if_fetch_unit: RTL and testbench
================================

Name: if_fetch_unit

Overview:
- Instruction fetch stage. It produces the pc/instruction pair consumed by the decode stage (decode pc_i, inst_i) and is the producer end of that interface.
- Owns the program counter and drives a req/ack instruction ROM port.
- Holds fetched words in a small FIFO so ROM latency and decode stalls are decoupled.
- Accepts a branch redirect from later stages, flushing everything already fetched.

Parameters:
- RESET_PC, 32'h0000_0000: first fetch address after reset.
- BUF_DEPTH, 2: instruction FIFO entries; legal values 2..8.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  reset; synchronous, active-high
- stall_i  in  1  decode stall; holds outputs
- branch_i  in  1  redirect request, sampled at the clock edge
- branch_target_i  in  32  redirect address
- rom_ce_o  out  1  ROM chip enable
- rom_req_o  out  1  fetch request
- rom_addr_o  out  32  fetch address (current fetch_pc)
- rom_ack_i  in  1  data valid this cycle
- rom_data_i  in  32  instruction word
- pc_o  out  32  to decode pc_i
- inst_o  out  32  to decode inst_i; 0 means bubble/NOP
- inst_valid_o  out  1  inst_o holds a real fetched instruction

Behaviour:
- Reset, on any edge with rst=1, including mid-request:
  - pc_o=0, inst_o=0, inst_valid_o=0, rom_ce_o=0.
  - fetch_pc=RESET_PC, FIFO emptied, state=S_RESET.
  - A pending ack is abandoned; the ROM must tolerate this.
- States:
  - S_RESET: rom_ce_o=0, rom_req_o=0. Goes to S_FETCH at the next edge.
  - S_FETCH: rom_ce_o=1. rom_req_o=(count<BUF_DEPTH), combinational.
  - S_DROP: rom_ce_o=1, rom_req_o=1, rom_addr_o keeps the old address. Waiting for an ack whose data is discarded.
- Handshake rules:
  - While rom_req_o=1, rom_addr_o is stable until an edge where rom_ack_i=1.
  - rom_data_i is captured at that edge.
  - rom_ack_i while rom_req_o=0 is ignored.
- Fetch on S_FETCH with ack:
  - Push {fetch_pc, rom_data_i} into the FIFO.
  - fetch_pc += 4; 32-bit wrap, so 32'hFFFF_FFFC -> 0.
- Output stage, evaluated at each edge, in priority order:
  1. branch_i=1 (overrides stall_i): pc_o holds, inst_o=0, inst_valid_o=0. FIFO cleared. fetch_pc={branch_target_i[31:2],2'b00}.
  2. stall_i=1: outputs hold, FIFO not popped. Pushes still occur.
  3. FIFO non-empty: pop the head to pc_o/inst_o, inst_valid_o=1.
  4. FIFO empty: inst_o=0, inst_valid_o=0, pc_o holds.
- Push and pop on the same edge: count is unchanged and order is preserved.
- Full FIFO: count==BUF_DEPTH drops rom_req_o combinationally. No overflow is possible.
- Redirect while a request is outstanding (rom_req_o=1, no ack this edge): go to S_DROP.
- Redirect on an edge where ack=1: that data is discarded and the state stays S_FETCH, now at the new target.
- S_DROP:
  - On ack: discard the data, go to S_FETCH.
  - A further branch_i in S_DROP overwrites fetch_pc and stays in S_DROP.
  - The held request address is the pre-redirect address. fetch_pc is tracked separately, and rom_addr_o switches to it on leaving S_DROP.
- Latency, without bypass: ack at edge N gives inst_valid_o=1 after edge N+1, provided the FIFO was empty and stall_i=0.

Optional Feature:
- Macro: FETCH_BYPASS_EN.
- Defined:
  - At an edge with ack in S_FETCH, FIFO empty, stall_i=0 and branch_i=0, the word goes directly to pc_o/inst_o with inst_valid_o=1 and is not pushed.
  - Latency is ack edge N -> valid after edge N.
- Undefined: every word passes through the FIFO; latency is 2 edges.
- All other rules are identical in both builds.

Test Plan:
- Reset, then a ROM with 1-cycle ack returning data 32'h3401_1100 at addr 0 and 32'h3402_0020 at addr 4:
  - rom_ce_o rises one cycle after rst falls.
  - pc_o/inst_o sequence is 0/3401_1100, then 4/3402_0020, with inst_valid_o=1.
  - No bubbles after the first valid output.
- Hold stall_i=1 for 5 cycles with ROM ack every cycle:
  - Outputs frozen; FIFO fills to BUF_DEPTH=2; rom_req_o=0 while full.
  - After release, pcs continue consecutively with none lost or duplicated.
- branch_i with target 32'h0000_0103 while a request to addr 8 is pending and ack arrives 3 cycles later:
  - Addr 8 data is never output.
  - rom_addr_o=8 is held until ack, then becomes 32'h100.
  - The next valid pc_o=32'h100.
- branch_i and stall_i together:
  - Bubble output (inst_o=0, inst_valid_o=0).
  - FIFO count=0 on the next cycle.
- fetch_pc=32'hFFFF_FFFC:
  - The following request address is 32'h0000_0000.
- Assert rst while S_DROP waits for ack:
  - All outputs return to reset values next cycle.
  - Fetch restarts at RESET_PC.
  - With FETCH_BYPASS_EN, first valid output comes after the ack edge itself; without it, one edge later.

Source files
------------

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, req/ack ROM port and a small FIFO that feeds decode.
// Optional macro FETCH_BYPASS_EN forwards an ack'd word straight to decode when the FIFO is empty.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_i,
  input  logic [31:0] branch_target_i,
  output logic        rom_ce_o,
  output logic        rom_req_o,
  output logic [31:0] rom_addr_o,
  input  logic        rom_ack_i,
  input  logic [31:0] rom_data_i,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int unsigned PTR_W = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(BUF_DEPTH);

  typedef enum logic [1:0] {S_RESET, S_FETCH, S_DROP} state_t;

  state_t            state;
  logic [31:0]       fetch_pc;
  logic [31:0]       drop_addr;
  logic [31:0]       fifo_pc   [BUF_DEPTH];
  logic [31:0]       fifo_inst [BUF_DEPTH];
  logic [PTR_W-1:0]  rd_ptr;
  logic [PTR_W-1:0]  wr_ptr;
  logic [CNT_W-1:0]  count;

  logic        ack_take;
  logic        fetch_ack;
  logic        bypass;
  logic        push;
  logic        pop;
  logic [31:0] target;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    rom_req_o  = 1'b0;
    rom_addr_o = fetch_pc;
    case (state)
      S_FETCH: rom_req_o = (count < FULL_CNT);
      S_DROP: begin
        rom_req_o  = 1'b1;
        rom_addr_o = drop_addr;
      end
      default: ;
    endcase
  end

  assign target    = branch_target_i & ~32'h3;
  assign ack_take  = rom_req_o & rom_ack_i;
  assign fetch_ack = (state == S_FETCH) & ack_take;
`ifdef FETCH_BYPASS_EN
  assign bypass    = fetch_ack & (count == '0) & ~stall_i & ~branch_i;
`else
  assign bypass    = 1'b0;
`endif
  assign push      = fetch_ack & ~branch_i & ~bypass;
  assign pop       = ~branch_i & ~stall_i & (count != '0);

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_inst[wr_ptr] <= rom_data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_RESET;
      fetch_pc     <= RESET_PC;
      drop_addr    <= RESET_PC;
      rom_ce_o     <= 1'b0;
      pc_o         <= '0;
      inst_o       <= '0;
      inst_valid_o <= 1'b0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
    end else begin
      case (state)
        S_RESET: begin
          state    <= S_FETCH;
          rom_ce_o <= 1'b1;
        end
        S_FETCH: begin
          if (branch_i) begin
            fetch_pc <= target;
            // an unanswered request must still be drained at its old address
            if (rom_req_o && !rom_ack_i) begin
              state     <= S_DROP;
              drop_addr <= fetch_pc;
            end
          end else if (ack_take) begin
            fetch_pc <= fetch_pc + 32'd4;
          end
        end
        S_DROP: begin
          if (branch_i) fetch_pc <= target;
          if (rom_ack_i) state <= S_FETCH;
        end
        default: state <= S_RESET;
      endcase

      if (branch_i) begin
        inst_o       <= '0;
        inst_valid_o <= 1'b0;
        rd_ptr       <= '0;
        wr_ptr       <= '0;
        count        <= '0;
      end else begin
        if (bypass) begin
          pc_o         <= fetch_pc;
          inst_o       <= rom_data_i;
          inst_valid_o <= 1'b1;
        end else if (stall_i) begin
          inst_valid_o <= inst_valid_o;
        end else if (count != '0) begin
          pc_o         <= fifo_pc[rd_ptr];
          inst_o       <= fifo_inst[rd_ptr];
          inst_valid_o <= 1'b1;
        end else begin
          inst_o       <= '0;
          inst_valid_o <= 1'b0;
        end
        if (push) wr_ptr <= next_ptr(wr_ptr);
        if (pop)  rd_ptr <= next_ptr(rd_ptr);
        if (push && !pop)      count <= count + 1'b1;
        else if (!push && pop) count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Scoreboard bench for if_fetch_unit: directed phases push expected pc streams, a monitor checks outputs.
module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_i = 1'b0;
  logic [31:0] branch_target_i = '0;
  logic        rom_ce_o;
  logic        rom_req_o;
  logic [31:0] rom_addr_o;
  logic        rom_ack_i = 1'b0;
  logic [31:0] rom_data_i = '0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  if_fetch_unit #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_i(branch_i),
    .branch_target_i(branch_target_i), .rom_ce_o(rom_ce_o), .rom_req_o(rom_req_o),
    .rom_addr_o(rom_addr_o), .rom_ack_i(rom_ack_i), .rom_data_i(rom_data_i),
    .pc_o(pc_o), .inst_o(inst_o), .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned outs   = 0;
  logic [31:0] exp_q[$];
  int          rom_lat = 0;
  logic        slow8 = 1'b0;
  int          wait_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h required %h", name, act, req);
  endtask

  function automatic logic [31:0] rom_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h3401_1100;
    if (a == 32'h4) return 32'h3402_0020;
    return a ^ 32'h5A5A_0001;
  endfunction

  task automatic sb_restart(input logic [31:0] base);
    exp_q.delete();
    for (int i = 0; i < 64; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic tick;
    @(negedge clk);
    #1;
  endtask

  // ROM model: answers after rom_lat waiting cycles; addr 8 takes 3 when slow8 is set
  always begin
    int lat;
    @(negedge clk);
    #2;
    if (rst || !rom_req_o) begin
      rom_ack_i = 1'b0;
      wait_cnt  = 0;
    end else begin
      lat = (slow8 && rom_addr_o == 32'h8) ? 3 : rom_lat;
      if (wait_cnt >= lat) begin
        rom_ack_i  = 1'b1;
        rom_data_i = rom_word(rom_addr_o);
        wait_cnt   = 0;
      end else begin
        rom_ack_i  = 1'b0;
        rom_data_i = 32'hDEAD_BEEF;
        wait_cnt++;
      end
    end
  end

  // Monitor: e_* hold the values the DUT sampled at the edge just before each negedge
  logic        e_rst = 1'b1, e_stall = 1'b0, e_branch = 1'b0, e_req = 1'b0, e_ack = 1'b0;
  logic [31:0] e_addr = '0;
  logic [31:0] mon_p;

  always begin
    @(negedge clk);
    if (!e_rst) begin
      if (e_req && !e_ack) begin
        check("addr_hold", rom_addr_o, e_addr);
        check("req_hold", rom_req_o, 1);
      end
      if (!inst_valid_o) begin
        check("bubble_inst", inst_o, 0);
      end else if (!e_branch && !e_stall) begin
        if (exp_q.size() == 0) begin
          total++;
          $display("FAIL sb_empty: got pc %h required no output", pc_o);
        end else begin
          mon_p = exp_q.pop_front();
          check("sb_pc", pc_o, mon_p);
          check("sb_inst", inst_o, rom_word(mon_p));
          outs++;
        end
      end
    end
    #4;
    e_rst = rst; e_stall = stall_i; e_branch = branch_i;
    e_req = rom_req_o; e_ack = rom_ack_i; e_addr = rom_addr_o;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check_reset_outputs;
    check("rst_pc", pc_o, 0);
    check("rst_inst", inst_o, 0);
    check("rst_valid", inst_valid_o, 0);
    check("rst_ce", rom_ce_o, 0);
    check("rst_req", rom_req_o, 0);
  endtask

  task automatic wait_valid(input string name, input logic [31:0] want_pc);
    int n = 0;
    while (!inst_valid_o && n < 10) begin tick; n++; end
    check({name, "_valid"}, inst_valid_o, 1);
    check({name, "_pc"}, pc_o, want_pc);
  endtask

  initial begin
    logic [31:0] sp, si, pre;
    int unsigned outs0;

    // reset, then streaming with 1-cycle ack
    sb_restart(32'h0);
    repeat (3) tick;
    check_reset_outputs();
    rst = 1'b0;
    tick;
    check("ce_rise", rom_ce_o, 1);
    check("first_bubble", inst_valid_o, 0);
    tick;
`ifdef FETCH_BYPASS_EN
    check("lat_bypass_valid", inst_valid_o, 1);
    check("lat_bypass_pc", pc_o, 0);
`else
    check("lat_fifo_valid", inst_valid_o, 0);
`endif
    tick;
    check("first_out_valid", inst_valid_o, 1);
`ifdef FETCH_BYPASS_EN
    check("second_out_pc", pc_o, 32'h4);
    check("second_out_inst", inst_o, 32'h3402_0020);
`else
    check("first_out_pc", pc_o, 32'h0);
    check("first_out_inst", inst_o, 32'h3401_1100);
`endif
    repeat (5) begin tick; check("no_bubble", inst_valid_o, 1); end

    // stall for 5 cycles: outputs frozen, FIFO fills, request drops
    sp = pc_o; si = inst_o;
    stall_i = 1'b1;
    repeat (5) begin
      tick;
      check("stall_pc", pc_o, sp);
      check("stall_inst", inst_o, si);
      check("stall_valid", inst_valid_o, 1);
    end
    check("req_full", rom_req_o, 0);
    stall_i = 1'b0;
    outs0 = outs;
    repeat (6) tick;
    check("resume_count", outs - outs0, 6);

    // redirect while request to addr 8 is pending
    rst = 1'b1; slow8 = 1'b1; sb_restart(32'h0);
    repeat (2) tick;
    rst = 1'b0;
    repeat (3) tick;
    check("pre_branch_addr", rom_addr_o, 32'h8);
    branch_i = 1'b1; branch_target_i = 32'h0000_0103; sb_restart(32'h100);
    tick;
    branch_i = 1'b0;
    check("br_valid", inst_valid_o, 0);
    check("br_inst", inst_o, 0);
    check("drop_addr1", rom_addr_o, 32'h8);
    tick; check("drop_addr2", rom_addr_o, 32'h8);
    tick; check("drop_addr3", rom_addr_o, 32'h8);
    tick; check("drop_exit_addr", rom_addr_o, 32'h100);
    slow8 = 1'b0;
    wait_valid("br_first", 32'h100);

    // branch and stall together
    repeat (3) tick;
    sp = pc_o;
    branch_i = 1'b1; stall_i = 1'b1; branch_target_i = 32'h200; sb_restart(32'h200);
    tick;
    branch_i = 1'b0; stall_i = 1'b0;
    check("bs_inst", inst_o, 0);
    check("bs_valid", inst_valid_o, 0);
    check("bs_pc_hold", pc_o, sp);
    check("bs_req", rom_req_o, 1);
    check("bs_addr", rom_addr_o, 32'h200);
    wait_valid("bs_first", 32'h200);

    // 32-bit wrap of fetch_pc
    branch_i = 1'b1; branch_target_i = 32'hFFFF_FFF8; sb_restart(32'hFFFF_FFF8);
    tick;
    branch_i = 1'b0;
    check("wrap_addr0", rom_addr_o, 32'hFFFF_FFF8);
    tick; check("wrap_addr1", rom_addr_o, 32'hFFFF_FFFC);
    tick; check("wrap_addr2", rom_addr_o, 32'h0000_0000);
    outs0 = outs;
    repeat (4) tick;
    check("wrap_outs", outs - outs0, 4);

    // reset while waiting in S_DROP
    rom_lat = 4;
    tick;
    pre = rom_addr_o;
    branch_i = 1'b1; branch_target_i = 32'h300; sb_restart(32'h300);
    tick;
    branch_i = 1'b0;
    check("drop_hold", rom_addr_o, pre);
    tick;
    rst = 1'b1; rom_lat = 0; sb_restart(32'h0);
    tick;
    check_reset_outputs();
    rst = 1'b0;
    tick;
    check("rr_ce", rom_ce_o, 1);
    check("rr_addr", rom_addr_o, 32'h0);
    tick;
`ifdef FETCH_BYPASS_EN
    check("rr_lat", inst_valid_o, 1);
`else
    check("rr_lat", inst_valid_o, 0);
    tick;
`endif
    check("rr_valid", inst_valid_o, 1);
    check("rr_pc", pc_o, 32'h0);
    repeat (3) tick;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
